// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALUOp encodings and the nested per-stage control structs.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LWU   = 6'h27;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Each stage struct nests the controls of the stages after it, so a
  // pipeline register simply forwards the inner field.
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  typedef struct packed {
    logic     branch;
    logic     branch_ne;
    logic     mem_read;
    logic     mem_write;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       link;
    mem_ctrl_t  mem;
  } ex_ctrl_t;

  typedef struct packed {
    logic     jump;
    ex_ctrl_t ex;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode -> control table, plus whether rt is read as a source.
module ctrl_decode
  import mips_pkg::*;
#(
  parameter int EN_JUMP = 1
) (
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rt
);

  function automatic ctrl_t mk(input logic rd, input logic as, input logic m2r,
                               input logic rw, input logic mr, input logic mw,
                               input logic br, input logic [1:0] aop);
    ctrl_t c;
    c = '0;
    c.ex.reg_dst           = rd;
    c.ex.alu_src           = as;
    c.ex.mem.wb.mem_to_reg = m2r;
    c.ex.mem.wb.reg_write  = rw;
    c.ex.mem.mem_read      = mr;
    c.ex.mem.mem_write     = mw;
    c.ex.mem.branch        = br;
    c.ex.alu_op            = aop;
    return c;
  endfunction

  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl    = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT);
        uses_rt = 1'b1;
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU:
        ctrl = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD);
      OP_SB, OP_SH, OP_SW: begin
        ctrl    = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD);
        uses_rt = 1'b1;
      end
      OP_ADDI:
        ctrl = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD);
      OP_LUI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:
        ctrl = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT);
      OP_BEQ: begin
        ctrl    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB);
        uses_rt = 1'b1;
      end
      OP_BNE: begin
        ctrl                  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB);
        ctrl.ex.mem.branch_ne = 1'b1;
        uses_rt               = 1'b1;
      end
      OP_J: begin
        if (EN_JUMP != 0) ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        // Link writes PC+8 to $31 through the normal WB path.
        if (EN_JUMP != 0) begin
          ctrl.jump                 = 1'b1;
          ctrl.ex.link              = 1'b1;
          ctrl.ex.mem.wb.reg_write  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall, branch/jump flush and a saturating stall counter.
module pipe_ctrl_unit
  import mips_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int EN_JUMP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               mem_br_taken,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_link,
  output logic               mem_branch,
  output logic               mem_branch_ne,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_mem_to_reg,
  output logic               wb_reg_write,
  output logic               id_jump,
  output logic               stall,
  output logic               if_flush,
  output logic [CNT_W-1:0]   stall_cnt
);

  ctrl_t            dec;
  logic             uses_rt;
  ex_ctrl_t         ex_q;
  mem_ctrl_t        mem_q;
  wb_ctrl_t         wb_q;
  logic [REG_W-1:0] ex_rt;

  ctrl_decode #(.EN_JUMP(EN_JUMP)) u_dec (
    .opcode  (id_opcode),
    .ctrl    (dec),
    .uses_rt (uses_rt)
  );

  assign id_jump  = dec.jump;
  assign stall    = id_valid & ex_q.mem.mem_read & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
  // A jump held by a load-use stall must not flush until it actually leaves ID.
  assign if_flush = mem_br_taken | (id_valid & id_jump & ~stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      ex_rt     <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      if (mem_br_taken || stall || !id_valid) begin
        ex_q  <= '0;
        ex_rt <= '0;
      end else begin
        ex_q  <= dec.ex;
        ex_rt <= id_rt;
      end
      // The taken branch itself sits in MEM and still moves on to WB.
      mem_q <= mem_br_taken ? '0 : ex_q.mem;
      wb_q  <= mem_q.wb;
      if (stall && !mem_br_taken && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ALUOP_W'(ex_q.alu_op);
  assign ex_link       = ex_q.link;
  assign mem_branch    = mem_q.branch;
  assign mem_branch_ne = mem_q.branch_ne;
  assign mem_read      = mem_q.mem_read;
  assign mem_write     = mem_q.mem_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_reg_write  = wb_q.reg_write;

endmodule
